result_logger: RTL and testbench
================================

Name: result_logger

Overview:
- Sits directly downstream of the bit-counting unit and consumes its `result` / `done` pair.
- Captures each completed popcount result once, on the rising edge of `done`, into a small circular history buffer.
- Maintains running min, max and entry count; provides indexed, registered readback for the board display path (HEX digits driven from switch-selected index).

Parameters:
- WIDTH, 4, bit width of one result value (matches the counter's result width).
- DEPTH, 8, number of history entries; must be a power of two.
- IDX_W, $clog2(DEPTH), width of the read index and buffer pointers.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- result  input  WIDTH  popcount value from the bit counter; valid while done=1.
- done  input  1  bit counter completion flag; level, stays high until start drops.
- clear  input  1  synchronous, active-high history clear; same effect as reset on all logger state.
- rd_idx  input  IDX_W  history index; 0 = most recent capture, 1 = previous, and so on.
- rd_data  output  WIDTH  registered entry at rd_idx.
- rd_valid  output  1  registered; 1 when rd_idx < num_entries.
- last_val  output  WIDTH  most recently captured value.
- min_val  output  WIDTH  minimum over current history since reset/clear.
- max_val  output  WIDTH  maximum over current history since reset/clear.
- num_entries  output  IDX_W+1  number of valid entries, saturates at DEPTH.
- overflow  output  1  sticky; set when a capture overwrites the oldest entry.

Behaviour:
- Reset / clear:
  - wr_ptr=0, num_entries=0, last_val=0, min_val=0, max_val=0, overflow=0, rd_data=0, rd_valid=0.
  - Buffer contents are not zeroed; they are invalid because num_entries=0.
- Edge detect:
  - done_q is a registered copy of done. done_q resets to 1 so a done already high at reset release is not captured.
  - capture = done & ~done_q, one-cycle pulse.
- Capture, at the posedge where capture=1 and clear=0:
  - mem[wr_ptr] <= result; wr_ptr <= wr_ptr+1 (wraps DEPTH-1 -> 0); last_val <= result.
  - If num_entries==0: min_val <= result and max_val <= result.
  - Otherwise: min_val <= min(min_val, result) and max_val <= max(max_val, result), unsigned compare.
  - If num_entries<DEPTH: num_entries increments. Otherwise it holds at DEPTH and overflow <= 1.
- Running stats are never recomputed after overwrite. min/max reflect all captures since the last reset/clear, not only the live window. This is deliberate.
- Simultaneous clear and capture: clear wins and the capture is discarded. done_q still updates, so the same done pulse is not captured later.
- done held high for many cycles yields exactly one capture. done falling and rising again yields a new capture, even if result is unchanged.
- Readback:
  - addr = (wr_ptr - 1 - rd_idx) mod DEPTH, using IDX_W-bit wraparound arithmetic.
  - Next cycle: rd_data <= (rd_idx < num_entries) ? mem[addr] : 0, and rd_valid <= (rd_idx < num_entries). Read latency is 1 cycle.
  - A read on the same cycle as a capture sees the pre-capture state. The next cycle sees the new entry at index 0.
- Reset asserted mid-operation behaves as above. If done is held across reset, no capture occurs until done falls and rises again.

Decomposition:
- Package `logger_pkg`:
  - localparams RES_W=4, LOG_DEPTH=8.
  - typedefs: `result_t` (logic [RES_W-1:0]), `idx_t` (logic [$clog2(LOG_DEPTH)-1:0]), `count_t` (one bit wider than idx_t).
- Sub-module `rise_edge_detect`: clk, reset, in, pulse; register reset value is a parameter, set to 1 here.
- Storage is a plain register array inside result_logger; no RAM IP.

Test Plan:
- Reset held with done=1, release, hold done=1 for 5 cycles -> num_entries=0, no capture; lower done, raise with result=2 -> num_entries=1, last_val=2, min=max=2.
- Capture sequence 2,0,8,5 (each done pulse 3 cycles high, 2 low), read rd_idx=0..3 -> rd_data 5,8,0,2 one cycle after each index, rd_valid=1; rd_idx=4 -> rd_data=0, rd_valid=0; min_val=0, max_val=8.
- Nine captures of values 1..9 -> num_entries=8, overflow=1, rd_idx=7 returns 2, rd_idx=0 returns 9, min_val=1 retained.
- clear asserted on the same cycle as a done rising edge with result=7 -> all outputs 0, num_entries=0; done remains high -> still no capture.
- done held high 16 cycles with result=4 after a rise -> exactly one entry, num_entries=1.
- Readback on the capture cycle: rd_idx=0 with one prior entry 3, capture 6 -> rd_data=3 the next cycle, then 6 the cycle after.

Source files
------------

// File: rtl/logger_pkg.sv
// Shared widths and types for the popcount result logger.
package logger_pkg;
  localparam int RES_W     = 4;
  localparam int LOG_DEPTH = 8;

  typedef logic [RES_W-1:0]             result_t;
  typedef logic [$clog2(LOG_DEPTH)-1:0] idx_t;
  typedef logic [$clog2(LOG_DEPTH):0]   count_t;
endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle pulse on a rising edge of a level input; the history register's
// reset value is configurable so a level already high at reset is not seen as an edge.
module rise_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic in_q;

  always_ff @(posedge clk) begin
    if (reset) in_q <= RST_VAL;
    else       in_q <= in;
  end

  assign pulse = in & ~in_q;
endmodule

// File: rtl/result_logger.sv
// Circular history of popcount results with running min/max/count and
// one-cycle registered indexed readback (index 0 = newest).
module result_logger
  import logger_pkg::*;
#(
  parameter int WIDTH = RES_W,
  parameter int DEPTH = LOG_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  input  logic             done,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] last_val,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic [IDX_W:0]   num_entries,
  output logic             overflow
);
  localparam logic [IDX_W:0]   FULL    = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic             capture, wr_en, rd_hit;
  logic [IDX_W-1:0] rd_addr;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [WIDTH-1:0] last_q, last_d, min_q, min_d, max_q, max_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d, ovf_q, ovf_d;

  // Edge history is only cleared by reset, so a pulse discarded by clear is never replayed.
  rise_edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk   (clk),
    .reset (reset),
    .in    (done),
    .pulse (capture)
  );

  assign wr_en = capture & ~clear & ~reset;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= result;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    num_d      = num_q;
    last_d     = last_q;
    min_d      = min_q;
    max_d      = max_q;
    ovf_d      = ovf_q;
    rd_addr    = wr_ptr_q - IDX_ONE - rd_idx;
    rd_hit     = {1'b0, rd_idx} < num_q;
    rd_valid_d = rd_hit;
    rd_data_d  = rd_hit ? mem_q[rd_addr] : '0;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + IDX_ONE;
      last_d   = result;
      if (num_q == '0) begin
        min_d = result;
        max_d = result;
      end else begin
        if (result < min_q) min_d = result;
        if (result > max_q) max_d = result;
      end
      if (num_q < FULL) num_d = num_q + CNT_ONE;
      else              ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q   <= '0;
      num_q      <= '0;
      last_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      num_q      <= num_d;
      last_q     <= last_d;
      min_q      <= min_d;
      max_q      <= max_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign last_val    = last_q;
  assign min_val     = min_q;
  assign max_val     = max_q;
  assign num_entries = num_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_result_logger.sv
// Randomized self-checking bench for result_logger against a queue-based history model.
module tb_result_logger;
  import logger_pkg::*;

  logic       clk = 1'b0;
  logic       reset, done, clear;
  logic [3:0] result;
  logic [2:0] rd_idx;
  logic [3:0] rd_data, last_val, min_val, max_val;
  logic       rd_valid, overflow;
  logic [3:0] num_entries;

  int checks = 0;
  int errors = 0;

  result_t hist[$];
  result_t m_last, m_min, m_max;
  bit      m_ovf;

  result_logger dut (
    .clk(clk), .reset(reset), .result(result), .done(done), .clear(clear),
    .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid), .last_val(last_val),
    .min_val(min_val), .max_val(max_val), .num_entries(num_entries), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    m_last = '0; m_min = '0; m_max = '0; m_ovf = 1'b0;
  endtask

  task automatic model_capture(input result_t v);
    if (hist.size() == 0) begin
      m_min = v; m_max = v;
    end else begin
      if (v < m_min) m_min = v;
      if (v > m_max) m_max = v;
    end
    if (hist.size() == LOG_DEPTH) begin
      m_ovf = 1'b1;
      void'(hist.pop_back());
    end
    hist.push_front(v);
    m_last = v;
  endtask

  function automatic result_t model_read(input int idx);
    return (idx < hist.size()) ? hist[idx] : result_t'(0);
  endfunction

  // done must already be low on entry
  task automatic pulse(input result_t v, input int hi, input int lo);
    result = v;
    done = 1'b1;
    repeat (hi) tick();
    done = 1'b0;
    repeat (lo) tick();
    model_capture(v);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; done = 1'b1; clear = 1'b0; result = 4'd9; rd_idx = '0;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    repeat (5) tick();
    checks++;
    if (num_entries !== 4'd0) begin errors++; $display("FAIL reset_held_num: got %0d expected 0", num_entries); end
    checks++;
    if (last_val !== 4'd0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: last %0d ovf %0d rdv %0d expected 0 0 0", last_val, overflow, rd_valid);
    end
    done = 1'b0;
    tick();
    pulse(4'd2, 1, 1);
    checks++;
    if (num_entries !== 4'd1 || last_val !== 4'd2) begin
      errors++; $display("FAIL first_capture: num %0d last %0d expected 1 2", num_entries, last_val);
    end
    checks++;
    if (min_val !== 4'd2 || max_val !== 4'd2) begin
      errors++; $display("FAIL first_minmax: min %0d max %0d expected 2 2", min_val, max_val);
    end
  endtask

  task automatic test_sequence();
    result_t vals[4] = '{4'd2, 4'd0, 4'd8, 4'd5};
    do_clear();
    foreach (vals[i]) pulse(vals[i], 3, 2);
    for (int i = 0; i <= 4; i++) begin
      rd_idx = 3'(i);
      tick();
      checks++;
      if (rd_data !== model_read(i) || rd_valid !== (i < hist.size())) begin
        errors++;
        $display("FAIL seq_read[%0d]: data %0d valid %0d expected %0d %0d", i, rd_data, rd_valid, model_read(i), (i < hist.size()));
      end
    end
    checks++;
    if (min_val !== 4'd0 || max_val !== 4'd8) begin
      errors++; $display("FAIL seq_minmax: min %0d max %0d expected 0 8", min_val, max_val);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int v = 1; v <= 9; v++) pulse(result_t'(v), 1, 1);
    checks++;
    if (num_entries !== 4'd8 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_state: num %0d ovf %0d expected 8 1", num_entries, overflow);
    end
    rd_idx = 3'd7;
    tick();
    checks++;
    if (rd_data !== 4'd2 || rd_data !== model_read(7)) begin
      errors++; $display("FAIL ovf_oldest: got %0d expected 2", rd_data);
    end
    rd_idx = 3'd0;
    tick();
    checks++;
    if (rd_data !== 4'd9) begin errors++; $display("FAIL ovf_newest: got %0d expected 9", rd_data); end
    checks++;
    if (min_val !== 4'd1 || max_val !== 4'd9) begin
      errors++; $display("FAIL ovf_minmax: min %0d max %0d expected 1 9", min_val, max_val);
    end
  endtask

  task automatic test_clear_collision();
    result = 4'd7; done = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    checks++;
    if (num_entries !== 4'd0 || last_val !== 4'd0 || min_val !== 4'd0 || max_val !== 4'd0 ||
        overflow !== 1'b0 || rd_data !== 4'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_collide: num %0d last %0d min %0d max %0d ovf %0d rd %0d rdv %0d expected all 0",
               num_entries, last_val, min_val, max_val, overflow, rd_data, rd_valid);
    end
    repeat (4) tick();
    checks++;
    if (num_entries !== 4'd0) begin errors++; $display("FAIL clear_no_replay: num %0d expected 0", num_entries); end
    done = 1'b0;
    tick();
  endtask

  task automatic test_done_held();
    do_clear();
    pulse(4'd4, 16, 1);
    checks++;
    if (num_entries !== 4'd1 || last_val !== 4'd4) begin
      errors++; $display("FAIL held_single: num %0d last %0d expected 1 4", num_entries, last_val);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    pulse(4'd3, 2, 2);
    rd_idx = 3'd0;
    result = 4'd6; done = 1'b1;
    tick();
    checks++;
    if (rd_data !== 4'd3) begin errors++; $display("FAIL read_on_capture: got %0d expected 3", rd_data); end
    tick();
    checks++;
    if (rd_data !== 4'd6) begin errors++; $display("FAIL read_after_capture: got %0d expected 6", rd_data); end
    done = 1'b0;
    tick();
    model_capture(4'd6);
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 11) == 0) do_clear();
      else pulse(result_t'($urandom_range(0, 15)), $urandom_range(1, 4), $urandom_range(1, 3));
      checks++;
      if (num_entries !== 4'(hist.size()) || last_val !== m_last || min_val !== m_min ||
          max_val !== m_max || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_stats[%0d]: num %0d last %0d min %0d max %0d ovf %0d expected %0d %0d %0d %0d %0d",
                 it, num_entries, last_val, min_val, max_val, overflow, hist.size(), m_last, m_min, m_max, m_ovf);
      end
      begin
        int idx = $urandom_range(0, 7);
        rd_idx = 3'(idx);
        tick();
        checks++;
        if (rd_data !== model_read(idx) || rd_valid !== (idx < hist.size())) begin
          errors++;
          $display("FAIL rand_read[%0d] idx %0d: data %0d valid %0d expected %0d %0d",
                   it, idx, rd_data, rd_valid, model_read(idx), (idx < hist.size()));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_overflow();
    test_clear_collision();
    test_done_held();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
